fetch_unit: RTL and testbench

Instruction fetch stage for the Pillar core. Holds the program counter, issues single-outstanding read requests to instruction memory over a req/ack handshake, latches the returned word into the instruction register, and presents it to the decode stage with a valid/ready handshake. Accepts PC redirects from the branch/jump logic and drains any in-flight request before refetching.

---
 rtl/fetch_unit.sv | 184 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem req/ack, IR with valid/ready to decode.
// Optional misaligned-redirect trap enabled by FETCH_MISALIGN_TRAP_EN.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_RST   | just out of reset, next cycle issues the first request
//   ST_REQ   | request to addr_q outstanding, waiting for ack
//   ST_HOLD  | ir_o/pc_o valid, waiting for decode to accept
//   ST_DRAIN | discarding an in-flight request after a redirect
//   ST_FAULT | misaligned redirect seen, fetch stopped until reset
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] ir_o,
    output logic [31:0] pc_o,
    output logic        ir_valid_o,
    input  logic        ir_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fault_o
`endif
);

    typedef enum logic [2:0] {
        ST_RST,
        ST_REQ,
        ST_HOLD,
        ST_DRAIN,
        ST_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] ir_pc_q, ir_pc_d;
    logic        valid_q, valid_d;

    logic        ack;
    logic        redir_ok;
    logic        redir_bad;
    logic        fault_pend;
    logic [31:0] target;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q, fault_d;
    assign fault_pend = fault_q;
    assign redir_ok   = redirect_i & ~fault_q;
    assign redir_bad  = redir_ok & (redirect_pc_i[1:0] != 2'b00);
`else
    assign fault_pend = 1'b0;
    assign redir_ok   = redirect_i;
    assign redir_bad  = 1'b0;
`endif

    assign ack    = req_q & imem_ack_i;
    assign target = redirect_pc_i & ~32'h0000_0003;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        ir_pc_d = ir_pc_q;
        valid_d = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d = fault_q;
`endif

        case (state_q)
            ST_RST: begin
                state_d = ST_REQ;
                req_d   = 1'b1;
                addr_d  = pc_q;
            end
            ST_REQ: begin
                if (ack) begin
                    ir_d    = imem_data_i;
                    ir_pc_d = pc_q;
                    pc_d    = pc_q + 32'd4;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ir_ready_i) begin
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (ack) begin
                    if (fault_pend) begin
                        req_d   = 1'b0;
                        state_d = ST_FAULT;
                    end else begin
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        state_d = ST_REQ;
                    end
                end
            end
            default: begin
                req_d = 1'b0;
            end
        endcase

        // Redirect overrides everything; an unacked request must still complete.
        if (redir_ok) begin
            pc_d    = target;
            valid_d = 1'b0;
            ir_d    = ir_q;
            ir_pc_d = ir_pc_q;
            if ((state_q == ST_REQ || state_q == ST_DRAIN) && !ack) begin
                state_d = ST_DRAIN;
                req_d   = 1'b1;
                addr_d  = addr_q;
            end else begin
                state_d = ST_REQ;
                req_d   = 1'b1;
                addr_d  = target;
            end
            if (redir_bad) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                fault_d = 1'b1;
`endif
                if (state_d == ST_REQ) begin
                    state_d = ST_FAULT;
                    req_d   = 1'b0;
                    addr_d  = addr_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RST;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            ir_q    <= 32'd0;
            ir_pc_q <= 32'd0;
            valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            ir_pc_q <= ir_pc_d;
            valid_q <= valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q <= fault_d;
`endif
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;
    assign ir_o        = ir_q;
    assign pc_o        = ir_pc_q;
    assign ir_valid_o  = valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fault_o     = fault_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for sequential fetches plus redirect/fault sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = 32'd0;
    logic [31:0] ir_o;
    logic [31:0] pc_o;
    logic        ir_valid_o;
    logic        ir_ready_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fault_o;
`endif

    int checks = 0;
    int errors = 0;
    int mem_lat = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .ir_o          (ir_o),
        .pc_o          (pc_o),
        .ir_valid_o    (ir_valid_o),
        .ir_ready_i    (ir_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fault_o       (fault_o)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 + (a << 8);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model with programmable latency, plus handshake/IR stability monitor.
    int          wait_cnt = 0;
    logic        prev_req = 1'b0, prev_ack = 1'b0, prev_valid = 1'b0, prev_rst = 1'b1;
    logic [31:0] prev_addr = 32'd0, prev_ir = 32'd0, prev_pc = 32'd0;

    always @(negedge clk) begin
        if (!prev_rst && prev_req && !prev_ack) begin
            check("req_held", {31'b0, imem_req_o}, 32'd1);
            check("addr_held", imem_addr_o, prev_addr);
        end
        if (!prev_rst && prev_valid && ir_valid_o) begin
            check("ir_stable", ir_o, prev_ir);
            check("pc_stable", pc_o, prev_pc);
        end
        if (reset || !imem_req_o) begin
            imem_ack_i = 1'b0;
            wait_cnt   = 0;
        end else if (imem_ack_i) begin
            imem_ack_i = 1'b0;
            wait_cnt   = 0;
        end else if (wait_cnt >= mem_lat) begin
            imem_ack_i  = 1'b1;
            imem_data_i = mem_word(imem_addr_o);
        end else begin
            wait_cnt++;
        end
        prev_req   = imem_req_o;
        prev_ack   = imem_ack_i;
        prev_addr  = imem_addr_o;
        prev_valid = ir_valid_o;
        prev_ir    = ir_o;
        prev_pc    = pc_o;
        prev_rst   = reset;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int budget, output int req_cycles);
        req_cycles = 0;
        for (int i = 0; i < budget && !ir_valid_o; i++) begin
            if (imem_req_o) req_cycles++;
            step();
        end
        check({name, "_valid"}, {31'b0, ir_valid_o}, 32'd1);
    endtask

    task automatic check_reset_values();
        check("rst_req", {31'b0, imem_req_o}, 32'd0);
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_valid", {31'b0, ir_valid_o}, 32'd0);
        check("rst_ir", ir_o, 32'h0);
        check("rst_pc", pc_o, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("rst_fault", {31'b0, fault_o}, 32'd0);
`endif
    endtask

    typedef struct {
        int          lat;
        int          stall;
        logic [31:0] exp_pc;
        logic [31:0] exp_ir;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int   n;
        int   vcount;
        logic seen_valid;

        vecs[0] = '{0, 0, 32'h0000_0000, 32'h0050_0093};
        vecs[1] = '{3, 0, 32'h0000_0004, 32'h0050_0493};
        vecs[2] = '{1, 5, 32'h0000_0008, 32'h0050_0893};
        vecs[3] = '{0, 2, 32'h0000_000C, 32'h0050_0C93};

        mem_lat = vecs[0].lat;
        reset   = 1'b1;
        repeat (3) step();
        check_reset_values();
        reset = 1'b0;
        step();
        check("first_req", {31'b0, imem_req_o}, 32'd1);
        check("first_addr", imem_addr_o, 32'h0);

        for (int i = 0; i < 4; i++) begin
            wait_valid("fetch", 20, n);
            check("vec_ir", ir_o, vecs[i].exp_ir);
            check("vec_pc", pc_o, vecs[i].exp_pc);
            check("vec_req_cycles", 32'(n), 32'(vecs[i].lat + 1));
            check("vec_req_low", {31'b0, imem_req_o}, 32'd0);
            if (vecs[i].stall > 0) begin
                repeat (vecs[i].stall) step();
                check("stall_req_low", {31'b0, imem_req_o}, 32'd0);
                check("stall_valid", {31'b0, ir_valid_o}, 32'd1);
                check("stall_pc", pc_o, vecs[i].exp_pc);
            end
            mem_lat    = (i < 3) ? vecs[i + 1].lat : 2;
            ir_ready_i = 1'b1;
            step();
            ir_ready_i = 1'b0;
            check("next_req", {31'b0, imem_req_o}, 32'd1);
            check("next_addr", imem_addr_o, vecs[i].exp_pc + 32'd4);
            check("next_valid", {31'b0, ir_valid_o}, 32'd0);
        end

        // Redirect while request to 0x10 is pending, ack two cycles later.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        step();
        redirect_i = 1'b0;
        check("drain_req", {31'b0, imem_req_o}, 32'd1);
        check("drain_addr", imem_addr_o, 32'h0000_0010);
        check("drain_valid", {31'b0, ir_valid_o}, 32'd0);
        n = 0;
        seen_valid = 1'b0;
        while (imem_addr_o == 32'h0000_0010 && n < 20) begin
            step();
            n++;
            seen_valid = seen_valid | ir_valid_o;
        end
        check("drain_cycles", 32'(n), 32'd2);
        check("drain_no_valid", {31'b0, seen_valid}, 32'd0);
        check("drain_new_req", {31'b0, imem_req_o}, 32'd1);
        check("drain_new_addr", imem_addr_o, 32'h0000_0100);
        mem_lat = 0;
        wait_valid("redir", 20, n);
        check("redir_pc", pc_o, 32'h0000_0100);
        check("redir_ir", ir_o, 32'h0051_0093);

        // Redirect simultaneous with ir_ready_i in HOLD.
        ir_ready_i    = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        step();
        ir_ready_i = 1'b0;
        redirect_i = 1'b0;
        check("hold_redir_req", {31'b0, imem_req_o}, 32'd1);
        check("hold_redir_addr", imem_addr_o, 32'h0000_0200);
        check("hold_redir_valid", {31'b0, ir_valid_o}, 32'd0);
        wait_valid("hold_redir", 20, n);
        check("hold_redir_pc", pc_o, 32'h0000_0200);
        check("hold_redir_ir", ir_o, 32'h0052_0093);

        // Redirect in the same cycle as a zero-wait ack.
        ir_ready_i = 1'b1;
        step();
        ir_ready_i = 1'b0;
        check("ackredir_addr0", imem_addr_o, 32'h0000_0204);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0300;
        step();
        redirect_i = 1'b0;
        check("ackredir_req", {31'b0, imem_req_o}, 32'd1);
        check("ackredir_addr", imem_addr_o, 32'h0000_0300);
        check("ackredir_valid", {31'b0, ir_valid_o}, 32'd0);
        wait_valid("ackredir", 20, n);
        check("ackredir_pc", pc_o, 32'h0000_0300);
        check("ackredir_ir", ir_o, 32'h0053_0093);

        // PC wrap at the top of the address space.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        check("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
        wait_valid("wrap", 20, n);
        check("wrap_pc", pc_o, 32'hFFFF_FFFC);
        check("wrap_ir", ir_o, 32'h004F_FC93);
        ir_ready_i = 1'b1;
        step();
        ir_ready_i = 1'b0;
        check("wrap_next_addr", imem_addr_o, 32'h0000_0000);
        wait_valid("wrap_next", 20, n);
        check("wrap_next_pc", pc_o, 32'h0000_0000);
        check("wrap_next_ir", ir_o, 32'h0050_0093);

        // Misaligned redirect target.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0102;
        step();
        redirect_i = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("fault_set", {31'b0, fault_o}, 32'd1);
        check("fault_req", {31'b0, imem_req_o}, 32'd0);
        check("fault_valid", {31'b0, ir_valid_o}, 32'd0);
        repeat (4) step();
        check("fault_no_req", {31'b0, imem_req_o}, 32'd0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0000;
        step();
        redirect_i = 1'b0;
        repeat (3) step();
        check("fault_ignore_req", {31'b0, imem_req_o}, 32'd0);
        check("fault_sticky", {31'b0, fault_o}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("fault_cleared", {31'b0, fault_o}, 32'd0);
        step();
`else
        check("misalign_req", {31'b0, imem_req_o}, 32'd1);
        check("misalign_addr", imem_addr_o, 32'h0000_0100);
        wait_valid("misalign", 20, n);
        check("misalign_pc", pc_o, 32'h0000_0100);
`endif

        // Reset with a request outstanding.
        mem_lat    = 5;
        ir_ready_i = 1'b1;
        step();
        ir_ready_i = 1'b0;
        reset = 1'b1;
        repeat (2) step();
        check_reset_values();
        mem_lat = 0;
        reset   = 1'b0;
        step();
        check("rerst_req", {31'b0, imem_req_o}, 32'd1);
        check("rerst_addr", imem_addr_o, 32'h0000_0000);
        wait_valid("rerst", 20, n);
        check("rerst_pc", pc_o, 32'h0000_0000);

        // Peak throughput: one instruction every two cycles with ready held high.
        ir_ready_i = 1'b1;
        vcount = 0;
        repeat (8) begin
            step();
            if (ir_valid_o) vcount++;
        end
        ir_ready_i = 1'b0;
        check("throughput", 32'(vcount), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
